inst_encoder_loader: RTL and testbench

Instruction encoder and program loader for the single-cycle RISC-V core. It accepts decoded instruction fields (format, opcode, funct3/funct7, rs1/rs2/rd, immediate) over a valid/ready stream. It packs each beat into a 32-bit RV32I word, using the same format encoding the datapath decodes. Encoded words are written sequentially into instruction memory from a programmable base address. It is used by testbenches and the boot path to fill instruction memory before the core is released.

---
 rtl/inst_encoder_loader_if.sv | 39 +++
 rtl/inst_encoder_loader.sv | 153 +++++++++++++++
 tb/tb_inst_encoder_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_loader_if.sv
// Stream/memory bundle for the RV32I instruction encoder and program loader.
// master = beat source and instruction memory side, slave = the loader.
interface inst_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        inst_type;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              err;

    modport master (
        output start, base_addr, in_valid, in_last, inst_type, opcode, funct3,
               funct7, rs1, rs2, rd, imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, count, err
    );

    modport slave (
        input  start, base_addr, in_valid, in_last, inst_type, opcode, funct3,
               funct7, rs1, rs2, rd, imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, count, err
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// Packs decoded RV32I fields into instruction words and writes them sequentially
// into instruction memory. Optional immediate range check: INST_ENC_RANGE_CHECK_EN.
module inst_encoder_loader #(
    parameter int ADDR_W   = 8,
    parameter int MAX_INST = 256
) (
    input logic                 clk,
    input logic                 rst_n,
    inst_encoder_loader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        DRAIN = 2'b10
    } state_t;

    localparam logic [ADDR_W:0]   MAX_CNT  = (ADDR_W + 1)'(MAX_INST);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W-1:0] addr_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              done_r;
    logic              err_r;

    logic              in_ready_s;
    logic              accept_s;
    logic [ADDR_W:0]   count_nxt_s;
    logic [31:0]       enc_word_s;

    function automatic logic [31:0] encode_inst(
        input logic [2:0]  inst_type,
        input logic [6:0]  opcode,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd,
        input logic [31:0] imm
    );
        logic [31:0] word;
        case (inst_type)
            3'b000:  word = {imm[11:0], rs1, funct3, rd, opcode};
            3'b001:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            3'b010:  word = {funct7, rs2, rs1, funct3, rd, opcode};
            3'b011:  word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            default: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        endcase
        return word;
    endfunction

`ifdef INST_ENC_RANGE_CHECK_EN
    // Bits above the format's sign bit must all equal it; branch/jump offsets must be even.
    function automatic logic imm_in_range(input logic [2:0] inst_type, input logic [31:0] imm);
        logic ok;
        case (inst_type)
            3'b000, 3'b001: ok = (imm[31:11] == {21{imm[31]}});
            3'b010:         ok = 1'b1;
            3'b011:         ok = (imm[31:12] == {20{imm[31]}}) && !imm[0];
            default:        ok = (imm[31:20] == {12{imm[31]}}) && !imm[0];
        endcase
        return ok;
    endfunction
`else
    logic unused_imm_s;
    assign unused_imm_s = ^bus.imm[31:21];
`endif

    // Accept a beat only in LOAD when the one-entry output register is free or draining now.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == LOAD) begin
            in_ready_s = !mem_we_r || bus.mem_ready;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s    = in_ready_s && bus.in_valid;
    assign count_nxt_s = count_r + CNT_ONE;
    assign enc_word_s  = encode_inst(bus.inst_type, bus.opcode, bus.funct3, bus.funct7,
                                     bus.rs1, bus.rs2, bus.rd, bus.imm);

    // Session FSM with the memory write register and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            addr_ptr_r  <= {ADDR_W{1'b0}};
            count_r     <= {(ADDR_W+1){1'b0}};
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'h0000_0000;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r    <= LOAD;
                        addr_ptr_r <= bus.base_addr;
                        count_r    <= {(ADDR_W+1){1'b0}};
                        err_r      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= addr_ptr_r;
                        mem_wdata_r <= enc_word_s;
                        addr_ptr_r  <= addr_ptr_r + ADDR_ONE;
                        count_r     <= count_nxt_s;
`ifdef INST_ENC_RANGE_CHECK_EN
                        if (!imm_in_range(bus.inst_type, bus.imm)) begin
                            err_r <= 1'b1;
                        end
`endif
                        // A full session ends like an explicit last beat.
                        if (bus.in_last || (count_nxt_s == MAX_CNT)) begin
                            state_r <= DRAIN;
                        end
                    end else if (mem_we_r && bus.mem_ready) begin
                        mem_we_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!mem_we_r || bus.mem_ready) begin
                        mem_we_r <= 1'b0;
                        state_r  <= IDLE;
                        done_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    mem_we_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.busy      = (state_r != IDLE);
    assign bus.done      = done_r;
    assign bus.count     = count_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: encodings, handshake, stalls, wrap,
// forced session end, reset and (when defined) INST_ENC_RANGE_CHECK_EN.
module tb_inst_encoder_loader;
    localparam int ADDR_W   = 8;
    localparam int MAX_INST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    int                wr_cyc_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];

    always #5 clk = ~clk;

    inst_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder_loader #(.ADDR_W(ADDR_W), .MAX_INST(MAX_INST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory-side log of every completed write.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.mem_we && bus.mem_ready) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic compare_log(input string tag);
        check_val({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
        for (int i = 0; i < wr_addr_q.size() && i < exp_addr_q.size(); i++) begin
            check_val($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(exp_addr_q[i]));
            check_val($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data_q[i]);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic start_session(input logic [ADDR_W-1:0] base);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = base;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Presents one beat and returns just after the edge that accepts it.
    task automatic send_beat(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                             input logic [4:0] rdv, input logic [31:0] im, input logic last);
        int guard = 0;
        @(negedge clk);
        bus.inst_type = t;
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.funct7    = f7;
        bus.rs1       = r1;
        bus.rs2       = r2;
        bus.rd        = rdv;
        bus.imm       = im;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
        #3;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            #3;
            guard++;
        end
        if (!bus.in_ready) check_val("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_session_end(input string tag);
        int pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) pulses++;
        end
        check_val({tag, "_done_pulses"}, 32'(pulses), 32'd1);
        check_val({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.base_addr = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.inst_type = 3'b000; bus.opcode = 7'h00; bus.funct3 = 3'h0; bus.funct7 = 7'h00;
        bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.rd = 5'd0; bus.imm = 32'h0; bus.mem_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_count", 32'(bus.count), 32'd0);
        check_val("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;

        // Session 1: single addi, garbage in rs2/funct7.
        start_session(8'h10);
        check_val("s1_busy", 32'(bus.busy), 32'd1);
        send_beat(3'b000, 7'h13, 3'd0, 7'h55, 5'd0, 5'd31, 5'd1, 32'd5, 1'b1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_val("s1_mem_we", 32'(bus.mem_we), 32'd1);
        check_val("s1_mem_addr", 32'(bus.mem_addr), 32'h10);
        check_val("s1_mem_wdata", bus.mem_wdata, 32'h0050_0093);
        check_val("s1_count", 32'(bus.count), 32'd1);
        wait_session_end("s1");
        expect_write(8'h10, 32'h0050_0093);
        compare_log("s1");

        // Session 2: sw then add back to back.
        start_session(8'h10);
        send_beat(3'b001, 7'h23, 3'd2, 7'h7F, 5'd1, 5'd2, 5'd31, 32'd8, 1'b0);
        send_beat(3'b010, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF, 1'b1);
        bus.in_valid = 1'b0;
        wait_session_end("s2");
        check_val("s2_count", 32'(bus.count), 32'd2);
        if (wr_cyc_q.size() == 2) check_val("s2_back_to_back", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd1);
        expect_write(8'h10, 32'h0020_A423);
        expect_write(8'h11, 32'h0020_81B3);
        compare_log("s2");

        // Session 3: beq +8, beq -8, jal with garbage in unused fields.
        start_session(8'h20);
        send_beat(3'b011, 7'h63, 3'd0, 7'h2A, 5'd1, 5'd2, 5'd17, 32'd8, 1'b0);
        send_beat(3'b011, 7'h63, 3'd0, 7'h15, 5'd1, 5'd2, 5'd9, 32'hFFFF_FFF8, 1'b0);
        send_beat(3'b111, 7'h6F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd1, 32'd16, 1'b1);
        bus.in_valid = 1'b0;
        wait_session_end("s3");
        check_val("s3_count", 32'(bus.count), 32'd3);
        expect_write(8'h20, 32'h0020_8463);
        expect_write(8'h21, 32'hFE20_8CE3);
        expect_write(8'h22, 32'h0100_00EF);
        compare_log("s3");

        // Session 4: memory stalls for 3 cycles with a second beat waiting.
        start_session(8'h30);
        bus.mem_ready = 1'b0;
        send_beat(3'b000, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd2, 32'hFFFF_FFFF, 1'b0);
        fork
            send_beat(3'b010, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    #2;
                    check_val($sformatf("s4_stall_we%0d", i), 32'(bus.mem_we), 32'd1);
                    check_val($sformatf("s4_stall_rdy%0d", i), 32'(bus.in_ready), 32'd0);
                    check_val($sformatf("s4_stall_addr%0d", i), 32'(bus.mem_addr), 32'h30);
                    check_val($sformatf("s4_stall_data%0d", i), bus.mem_wdata, 32'hFFF1_0113);
                end
                bus.mem_ready = 1'b1;
            end
        join
        bus.in_valid = 1'b0;
        wait_session_end("s4");
        expect_write(8'h30, 32'hFFF1_0113);
        expect_write(8'h31, 32'h0020_81B3);
        compare_log("s4");

        // Session 5: address wraps from 0xFF to 0x00.
        start_session(8'hFF);
        send_beat(3'b000, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0);
        send_beat(3'b010, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1);
        bus.in_valid = 1'b0;
        wait_session_end("s5");
        expect_write(8'hFF, 32'h0050_0093);
        expect_write(8'h00, 32'h0020_81B3);
        compare_log("s5");

        // Session 6: no in_last, forced end at MAX_INST; start while busy is ignored.
        start_session(8'h40);
        for (int k = 1; k <= 4; k++) begin
            if (k == 3) begin
                bus.start     = 1'b1;
                bus.base_addr = 8'h80;
            end
            send_beat(3'b000, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'(k), 1'b0);
            bus.start = 1'b0;
            expect_write(8'h40 + 8'(k - 1), 32'h0000_0093 | (32'(k) << 20));
        end
        @(negedge clk);
        bus.imm = 32'd5;
        #3;
        check_val("s6_no_accept", 32'(bus.in_ready), 32'd0);
        wait_session_end("s6");
        check_val("s6_count", 32'(bus.count), 32'd4);
        bus.in_valid = 1'b0;
        compare_log("s6");

        // Reset with a write pending.
        start_session(8'h50);
        bus.mem_ready = 1'b0;
        send_beat(3'b000, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst2_pending", 32'(bus.mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst2_mem_we", 32'(bus.mem_we), 32'd0);
        check_val("rst2_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_val("rst2_mem_wdata", bus.mem_wdata, 32'd0);
        check_val("rst2_busy", 32'(bus.busy), 32'd0);
        check_val("rst2_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst2_idle_busy", 32'(bus.busy), 32'd0);
        check_val("rst2_idle_rdy", 32'(bus.in_ready), 32'd0);
        compare_log("rst2");

        // Immediate out of range for I format.
        start_session(8'h60);
        send_beat(3'b000, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h0000_0800, 1'b1);
        bus.in_valid = 1'b0;
        wait_session_end("s7");
`ifdef INST_ENC_RANGE_CHECK_EN
        check_val("s7_err_sticky", 32'(bus.err), 32'd1);
`else
        check_val("s7_err_off", 32'(bus.err), 32'd0);
`endif
        expect_write(8'h60, 32'h8000_0093);
        compare_log("s7");
        start_session(8'h70);
        check_val("s8_err_cleared", 32'(bus.err), 32'd0);
        send_beat(3'b000, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1);
        bus.in_valid = 1'b0;
        wait_session_end("s8");
        expect_write(8'h70, 32'h0050_0093);
        compare_log("s8");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
